// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU operand sequencer:
//                FSM state encoding, opcode flag bit positions and the
//                wait-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      S_GET_OP = 3'd0,
      S_GET_A  = 3'd1,
      S_GET_B  = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_RESP   = 3'd5
   } seq_state_e;

   // Opcode bit that marks a unary operation (no operand B byte follows)
   localparam int OPC_UNARY_BIT = 6;
   // Opcode bit that requests a carry-in
   localparam int OPC_CARRY_BIT = 7;

   // Wait counter width; covers ALU latencies 1..15
   localparam int CNT_W = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_wait_cnt
//  Description : Loadable down-counter with a zero flag. Times the ALU
//                latency while the sequencer sits in WAIT. Saturates at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_wait_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load has priority over decrement; never wraps below zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule : alu_seq_wait_cnt
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_sequencer
//  Description : Front end of the ALU datapath. Assembles opcode / operand A
//                / optional operand B from a byte stream, issues the frame
//                with a one-cycle load strobe, waits ALU_LATENCY cycles and
//                returns the captured result and carry-out.
//                Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN - keeps the
//                last carry-out and feeds it back as carry-in for opcodes
//                with the carry bit set (multi-byte add/sub chains).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
   parameter int DATA_W      = 8,
   parameter int ALU_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   // Inbound byte stream
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   // ALU core interface
   output logic [DATA_W-1:0] alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_cin,
   output logic              alu_load,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cout,
   // Result stream
   output logic [DATA_W-1:0] res_data,
   output logic              res_cout,
   output logic              res_valid,
   input  logic              res_ready
);

   import alu_pkg::*;

   // Counter preload: the WAIT cycle that sees zero is the capture cycle
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LATENCY - 1);

   seq_state_e        state_q;
   logic              in_ready_q;
   logic              alu_load_q;
   logic              res_valid_q;
   logic [DATA_W-1:0] opcode_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res_data_q;
   logic              res_cout_q;

   logic              w_xfer;
   logic              w_cnt_load;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic              w_capture;

   assign w_xfer     = in_valid && in_ready_q;
   assign w_cnt_load = (state_q == S_ISSUE);
   assign w_cnt_dec  = (state_q == S_WAIT);
   assign w_capture  = (state_q == S_WAIT) && w_cnt_zero;

   alu_seq_wait_cnt #(
      .CNT_W      (CNT_W)
   ) u_wait_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (w_cnt_load),
      .load_val_i (LAT_LOAD),
      .dec_i      (w_cnt_dec),
      .zero_o     (w_cnt_zero)
   );

   // Frame sequencing FSM with registered handshake/strobe outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_GET_OP;
         in_ready_q  <= 1'b1;
         alu_load_q  <= 1'b0;
         res_valid_q <= 1'b0;
         opcode_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_data_q  <= '0;
         res_cout_q  <= 1'b0;
      end else begin
         alu_load_q <= 1'b0;
         case (state_q)
            S_GET_OP: begin
               if (w_xfer) begin
                  opcode_q <= in_data;
                  state_q  <= S_GET_A;
               end
            end
            S_GET_A: begin
               if (w_xfer) begin
                  a_q <= in_data;
                  if (opcode_q[OPC_UNARY_BIT]) begin
                     b_q        <= '0;
                     state_q    <= S_ISSUE;
                     in_ready_q <= 1'b0;
                     alu_load_q <= 1'b1;
                  end else begin
                     state_q <= S_GET_B;
                  end
               end
            end
            S_GET_B: begin
               if (w_xfer) begin
                  b_q        <= in_data;
                  state_q    <= S_ISSUE;
                  in_ready_q <= 1'b0;
                  alu_load_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (w_cnt_zero) begin
                  res_data_q  <= alu_result;
                  res_cout_q  <= alu_cout;
                  res_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_GET_OP;
               end
            end
            default: begin
               state_q     <= S_GET_OP;
               in_ready_q  <= 1'b1;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   logic carry_q;

   // Chain carry: remember the carry-out of every captured result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else if (w_capture) begin
         carry_q <= alu_cout;
      end
   end

   assign alu_cin = opcode_q[OPC_CARRY_BIT] & carry_q;
`else
   assign alu_cin = opcode_q[OPC_CARRY_BIT];
`endif

   assign in_ready   = in_ready_q;
   assign alu_opcode = opcode_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_load   = alu_load_q;
   assign res_data   = res_data_q;
   assign res_cout   = res_cout_q;
   assign res_valid  = res_valid_q;

endmodule : alu_operand_sequencer
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_operand_sequencer
//  Description : Self-checking bench for alu_operand_sequencer with a stub
//                ALU (result = A + B + cin, cout = carry).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

   localparam int DATA_W = 8;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] alu_opcode;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic              alu_cin;
   logic              alu_load;
   logic [DATA_W-1:0] alu_result;
   logic              alu_cout;
   logic [DATA_W-1:0] res_data;
   logic              res_cout;
   logic              res_valid;
   logic              res_ready = 1'b0;

   int tests = 0;
   int fails = 0;

   alu_operand_sequencer #(
      .DATA_W      (DATA_W),
      .ALU_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_load   (alu_load),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .res_data   (res_data),
      .res_cout   (res_cout),
      .res_valid  (res_valid),
      .res_ready  (res_ready)
   );

   always #5 clk = ~clk;

   // Stub ALU
   logic [DATA_W:0] sum;
   assign sum        = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_cin};
   assign alu_result = sum[DATA_W-1:0];
   assign alu_cout   = sum[DATA_W];

   typedef struct {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      bit         gap;
      int         hold;
      logic [7:0] exp_b;
      logic       exp_cin;
      logic [7:0] exp_res;
      logic       exp_cout;
   } frame_t;

   frame_t vec [8];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Offer one byte (optionally after an idle cycle) until it is accepted
   task automatic push_byte(input logic [7:0] d, input bit gap);
      int n;
      if (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'hEE;
      end
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d;
         n++;
      end while (!in_ready && n < 20);
      chk("in_ready_at_push", int'(in_ready), 1);
   endtask

   task automatic run_frame(input frame_t f);
      int lat;
      bit busy_ok;
      bit stable_ok;
      logic [7:0] held;
      push_byte(f.op, f.gap);
      push_byte(f.a, f.gap);
      if (!f.op[6]) push_byte(f.b, f.gap);
      // Cycle T+1
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      chk("alu_load_T1", int'(alu_load), 1);
      chk("alu_opcode", int'(alu_opcode), int'(f.op));
      chk("alu_a", int'(alu_a), int'(f.a));
      chk("alu_b", int'(alu_b), int'(f.exp_b));
      chk("alu_cin", int'(alu_cin), int'(f.exp_cin));
      chk("in_ready_issue", int'(in_ready), 0);
      lat       = 1;
      busy_ok   = 1'b1;
      stable_ok = 1'b1;
      while (!res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (in_ready || alu_load) busy_ok = 1'b0;
         if (alu_opcode !== f.op || alu_a !== f.a || alu_b !== f.exp_b) stable_ok = 1'b0;
      end
      chk("res_latency", lat, LAT + 2);
      chk("busy_during_wait", int'(busy_ok), 1);
      chk("operands_stable", int'(stable_ok), 1);
      chk("res_data", int'(res_data), int'(f.exp_res));
      chk("res_cout", int'(res_cout), int'(f.exp_cout));
      if (f.hold > 0) begin
         held      = res_data;
         stable_ok = 1'b1;
         for (int i = 0; i < f.hold; i++) begin
            res_ready = 1'b0;
            @(negedge clk);
            if (!res_valid || res_data !== held || in_ready) stable_ok = 1'b0;
         end
         chk("backpressure_hold", int'(stable_ok), 1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("in_ready_after_resp", int'(in_ready), 1);
      chk("res_valid_cleared", int'(res_valid), 0);
   endtask

   initial begin
      bit quiet;
      //        op     a      b      gap hold exp_b  cin  res    cout
      vec[0] = '{8'h01, 8'h10, 8'h22, 0, 0, 8'h22, 1'b0, 8'h32, 1'b0};
      vec[1] = '{8'h41, 8'h7F, 8'h00, 0, 0, 8'h00, 1'b0, 8'h7F, 1'b0};
      vec[2] = '{8'h01, 8'h10, 8'h22, 1, 5, 8'h22, 1'b0, 8'h32, 1'b0};
      vec[3] = '{8'h01, 8'hFF, 8'h01, 0, 0, 8'h01, 1'b0, 8'h00, 1'b1};
      vec[4] = '{8'h81, 8'h00, 8'h00, 0, 0, 8'h00, 1'b1, 8'h01, 1'b0};
      vec[5] = '{8'h02, 8'hF0, 8'h20, 1, 0, 8'h20, 1'b0, 8'h10, 1'b1};
      vec[6] = '{8'hC1, 8'h05, 8'h00, 0, 2, 8'h00, 1'b1, 8'h06, 1'b0};
      vec[7] = '{8'h41, 8'h80, 8'h00, 1, 0, 8'h00, 1'b0, 8'h80, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_alu_load", int'(alu_load), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_res_cout", int'(res_cout), 0);
      chk("rst_alu_opcode", int'(alu_opcode), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_cin", int'(alu_cin), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);

      for (int i = 0; i < 8; i++) begin
         run_frame(vec[i]);
      end

      // Reset asserted while waiting on the ALU
      push_byte(8'h01, 1'b0);
      push_byte(8'h10, 1'b0);
      push_byte(8'h22, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midwait_rst_res_valid", int'(res_valid), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midwait_in_ready", int'(in_ready), 1);
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_valid || alu_load) quiet = 1'b0;
      end
      chk("midwait_no_result", int'(quiet), 1);
      run_frame(vec[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_alu_operand_sequencer
`default_nettype wire
